// File: rtl/sram_write_ctrl.sv
// Packet writer: places arbitrated packet words into a circular SRAM buffer,
// emits one descriptor per packet and tracks free buffer space.
module sram_write_ctrl #(
  parameter int data_width  = 64,
  parameter int addr_width  = 10,
  parameter int port_width  = 4,
  parameter int max_pkt_len = 64,
  parameter int len_width   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_sop,
  input  logic                  in_vld,
  input  logic                  in_eop,
  input  logic [data_width-1:0] in_data,
  input  logic [port_width-1:0] in_des_port,
  output logic                  in_ready,
  output logic                  sram_wr_en,
  output logic [addr_width-1:0] sram_wr_addr,
  output logic [data_width-1:0] sram_wr_data,
  output logic                  desc_vld,
  input  logic                  desc_ready,
  output logic [addr_width-1:0] desc_addr,
  output logic [len_width-1:0]  desc_len,
  output logic [port_width-1:0] desc_port,
  output logic                  desc_err,
  input  logic                  rel_vld,
  input  logic [len_width-1:0]  rel_len,
  output logic [addr_width:0]   free_cnt,
  output logic [1:0]            dbg_state
);

  localparam logic [len_width-1:0] MaxLen  = len_width'(max_pkt_len);
  localparam logic [addr_width:0]  Depth   = (addr_width+1)'(1 << addr_width);
  localparam logic [addr_width:0]  MinFree = (addr_width+1)'(max_pkt_len);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DESC  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [addr_width-1:0] r_wr_ptr;
  logic [addr_width-1:0] r_start;
  logic [len_width-1:0]  r_len;
  logic [port_width-1:0] r_port;
  logic                  r_err;
  logic [addr_width:0]   r_free_cnt;
  logic                  r_wr_en;
  logic [addr_width-1:0] r_wr_addr;
  logic [data_width-1:0] r_wr_data;
  logic [addr_width-1:0] r_desc_addr;
  logic [len_width-1:0]  r_desc_len;
  logic [port_width-1:0] r_desc_port;
  logic                  r_desc_err;

  logic                  w_in_ready;
  logic                  w_sop_acc;
  logic                  w_wr_acc;
  logic                  w_drop;
  logic                  w_sop_err;
  logic                  w_eop_acc;
  logic [len_width-1:0]  w_len_nxt;
  logic                  w_err_nxt;
  logic [addr_width+1:0] w_free_sum;
  logic [addr_width:0]   w_free_nxt;

  // Handshakes: the input stream transfers on (in_sop|in_vld|in_eop) & in_ready;
  // a descriptor transfers on desc_vld & desc_ready and is held stable until then.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_sop_acc   = 1'b0;
    w_wr_acc    = 1'b0;
    w_drop      = 1'b0;
    w_sop_err   = 1'b0;
    w_eop_acc   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = (r_free_cnt >= MinFree);
        if (in_sop && w_in_ready) begin
          w_sop_acc   = 1'b1;
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        w_in_ready = 1'b1;
        w_sop_err  = in_sop;
        if (in_vld) begin
          if (r_len < MaxLen) w_wr_acc = 1'b1;
          else                w_drop   = 1'b1;
        end
        if (in_eop) begin
          w_eop_acc   = 1'b1;
          w_state_nxt = DESC;
        end
      end
      DESC: begin
        if (desc_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_len_nxt = r_len + len_width'(w_wr_acc);
  assign w_err_nxt = r_err | w_drop | w_sop_err;

  // Write and release in the same cycle both apply; excess release saturates at depth.
  assign w_free_sum = {1'b0, r_free_cnt}
                    + (rel_vld ? (addr_width+2)'(rel_len) : '0)
                    - (addr_width+2)'(w_wr_acc);
  assign w_free_nxt = (w_free_sum > {1'b0, Depth}) ? Depth : w_free_sum[addr_width:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_start     <= '0;
      r_len       <= '0;
      r_port      <= '0;
      r_err       <= 1'b0;
      r_free_cnt  <= Depth;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_desc_addr <= '0;
      r_desc_len  <= '0;
      r_desc_port <= '0;
      r_desc_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_free_cnt <= w_free_nxt;
      r_wr_en    <= w_wr_acc;
      if (w_sop_acc) begin
        r_port  <= in_des_port;
        r_start <= r_wr_ptr;
        r_len   <= '0;
        r_err   <= 1'b0;
      end else begin
        r_len <= w_len_nxt;
        r_err <= w_err_nxt;
      end
      if (w_wr_acc) begin
        r_wr_addr <= r_wr_ptr;
        r_wr_data <= in_data;
        r_wr_ptr  <= r_wr_ptr + addr_width'(1);
      end
      if (w_eop_acc) begin
        r_desc_addr <= r_start;
        r_desc_len  <= w_len_nxt;
        r_desc_port <= r_port;
        r_desc_err  <= w_err_nxt | (w_len_nxt == '0);
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign sram_wr_en   = r_wr_en;
  assign sram_wr_addr = r_wr_addr;
  assign sram_wr_data = r_wr_data;
  assign desc_vld     = (r_state == DESC);
  assign desc_addr    = r_desc_addr;
  assign desc_len     = r_desc_len;
  assign desc_port    = r_desc_port;
  assign desc_err     = r_desc_err;
  assign free_cnt     = r_free_cnt;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_sram_write_ctrl.sv
// Bench for sram_write_ctrl: directed packet scenarios plus random traffic,
// checked every cycle against a packet-level buffer model.
module tb_sram_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_sop = 1'b0, in_vld = 1'b0, in_eop = 1'b0;
  logic [63:0] in_data = '0;
  logic [3:0]  in_des_port = '0;
  logic        in_ready;
  logic        sram_wr_en;
  logic [9:0]  sram_wr_addr;
  logic [63:0] sram_wr_data;
  logic        desc_vld;
  logic        desc_ready = 1'b0;
  logic [9:0]  desc_addr;
  logic [6:0]  desc_len;
  logic [3:0]  desc_port;
  logic        desc_err;
  logic        rel_vld = 1'b0;
  logic [6:0]  rel_len = '0;
  logic [10:0] free_cnt;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_err = 0;
  int out_q[$];

  sram_write_ctrl dut (
    .clk(clk), .rst(rst), .in_sop(in_sop), .in_vld(in_vld), .in_eop(in_eop),
    .in_data(in_data), .in_des_port(in_des_port), .in_ready(in_ready),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .desc_vld(desc_vld), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_len(desc_len), .desc_port(desc_port), .desc_err(desc_err),
    .rel_vld(rel_vld), .rel_len(rel_len), .free_cnt(free_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Packet-level model: open packet, pending descriptor, pointer and free words.
  bit          m_busy = 0, m_desc = 0, m_err = 0;
  int          m_ptr = 0, m_free = 1024, m_len = 0, m_start = 0, m_port = 0;
  bit          e_wr = 0;
  int          e_waddr = 0;
  logic [63:0] e_wdata = '0;
  int          e_daddr = 0, e_dlen = 0, e_dport = 0;
  bit          e_derr = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_desc = 0; m_err = 0; m_ptr = 0; m_free = 1024; m_len = 0; e_wr = 0;
    end else begin
      int wr;
      wr = 0;
      e_wr = 0;
      if (m_desc) begin
        if (desc_ready) m_desc = 0;
      end else if (!m_busy) begin
        if (in_sop && m_free >= 64) begin
          m_busy = 1; m_start = m_ptr; m_port = int'(in_des_port); m_len = 0; m_err = 0;
        end
      end else begin
        if (in_sop) m_err = 1;
        if (in_vld) begin
          if (m_len < 64) begin
            e_wr = 1; e_waddr = m_ptr; e_wdata = in_data;
            m_ptr = (m_ptr + 1) % 1024; m_len++; wr = 1;
          end else m_err = 1;
        end
        if (in_eop) begin
          m_busy = 0; m_desc = 1;
          e_daddr = m_start; e_dlen = m_len; e_dport = m_port; e_derr = m_err || (m_len == 0);
        end
      end
      m_free = m_free - wr + (rel_vld ? int'(rel_len) : 0);
      if (m_free > 1024) m_free = 1024;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready", in_ready, (!m_desc && (m_busy || m_free >= 64)));
      chk("free_cnt", free_cnt, m_free);
      chk("sram_wr_en", sram_wr_en, e_wr);
      chk("desc_vld", desc_vld, m_desc);
      if (e_wr) begin
        chk("sram_wr_addr", sram_wr_addr, e_waddr);
        chk("sram_wr_data", sram_wr_data, e_wdata);
      end
      if (m_desc) begin
        chk("desc_addr", desc_addr, e_daddr);
        chk("desc_len", desc_len, e_dlen);
        chk("desc_port", desc_port, e_dport);
        chk("desc_err", desc_err, e_derr);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 300) begin cyc(); n++; end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send_pkt(input int port, input int n, input int max_gap, input bit mid_sop,
                          input int rel_at, input int rel_amt);
    wait_ready();
    in_sop = 1; in_des_port = 4'(port);
    cyc();
    in_sop = 0;
    if (n == 0) begin
      in_eop = 1;
      cyc();
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) cyc();
      in_vld = 1; in_data = {$urandom, $urandom}; in_eop = (i == n - 1);
      in_sop = mid_sop && (i == 0);
      if (i == rel_at) begin rel_vld = 1; rel_len = 7'(rel_amt); end
      cyc();
      in_vld = 0; in_eop = 0; in_sop = 0; rel_vld = 0; rel_len = '0;
    end
    in_vld = 0; in_eop = 0;
  endtask

  task automatic take_desc(input int stall);
    int n = 0;
    while (!desc_vld && n < 10) begin cyc(); n++; end
    if (!desc_vld) chk("desc_timeout", 0, 1);
    repeat (stall) cyc();
    out_q.push_back(e_dlen);
    desc_ready = 1;
    cyc();
    desc_ready = 0;
  endtask

  task automatic release_amt(input int amt);
    rel_vld = 1; rel_len = 7'(amt);
    cyc();
    rel_vld = 0; rel_len = '0;
  endtask

  task automatic release_all();
    while (out_q.size() > 0) release_amt(out_q.pop_front());
  endtask

  initial begin
    repeat (3) cyc();
    rst = 1;
    cyc();
    chk("rst_free", free_cnt, 1024);
    chk("rst_ready", in_ready, 1);
    chk("rst_desc_vld", desc_vld, 0);
    chk("rst_wr_en", sram_wr_en, 0);

    // Four words to port 5; descriptor arrives with the last write.
    send_pkt(5, 4, 0, 0, -1, 0);
    chk("p1_desc_vld", desc_vld, 1);
    chk("p1_last_wr_en", sram_wr_en, 1);
    chk("p1_last_addr", sram_wr_addr, 3);
    chk("p1_desc_addr", desc_addr, 0);
    chk("p1_desc_len", desc_len, 4);
    chk("p1_desc_port", desc_port, 5);
    chk("p1_desc_err", desc_err, 0);
    chk("p1_free", free_cnt, 1020);
    in_sop = 1; in_des_port = 4'd7;
    repeat (10) begin
      cyc();
      chk("stall_ready", in_ready, 0);
      chk("stall_len", desc_len, 4);
    end
    desc_ready = 1;
    cyc();
    desc_ready = 0;
    out_q.push_back(4);
    send_pkt(9, 3, 2, 0, -1, 0);
    chk("p2_desc_port", desc_port, 9);
    chk("p2_desc_addr", desc_addr, 4);
    take_desc(0);

    // Oversized packet is truncated at 64 words.
    send_pkt(2, 70, 0, 0, -1, 0);
    chk("long_len", desc_len, 64);
    chk("long_err", desc_err, 1);
    chk("long_addr", desc_addr, 7);
    take_desc(1);

    send_pkt(3, 0, 0, 0, -1, 0);
    chk("bare_len", desc_len, 0);
    chk("bare_err", desc_err, 1);
    take_desc(0);
    send_pkt(4, 2, 1, 1, -1, 0);
    chk("midsop_err", desc_err, 1);
    chk("midsop_len", desc_len, 2);
    take_desc(0);
    release_all();

    // Advance the write pointer to 1022, then wrap.
    for (int k = 0; k < 20 && m_ptr != 1022; k++) begin
      int n;
      n = 1022 - m_ptr;
      if (n > 64) n = 64;
      send_pkt(int'($urandom_range(0, 15)), n, 1, 0, -1, 0);
      take_desc(0);
      release_all();
    end
    chk("model_ptr", m_ptr, 1022);
    send_pkt(11, 4, 1, 0, -1, 0);
    chk("wrap_addr", desc_addr, 1022);
    chk("wrap_len", desc_len, 4);
    chk("wrap_last_addr", sram_wr_addr, 1);
    take_desc(0);
    release_all();
    chk("full_free", free_cnt, 1024);

    // Fill to 63 free words.
    for (int k = 0; k < 15; k++) begin
      send_pkt(1, 64, 0, 0, -1, 0);
      take_desc(0);
    end
    send_pkt(1, 1, 0, 0, -1, 0);
    take_desc(0);
    out_q.delete();
    chk("bp_free", free_cnt, 63);
    chk("bp_ready", in_ready, 0);
    in_sop = 1;
    repeat (3) cyc();
    in_sop = 0;
    chk("bp_sop_ignored", desc_vld, 0);
    chk("bp_ready2", in_ready, 0);
    release_amt(1);
    chk("bp_free64", free_cnt, 64);
    chk("bp_ready_back", in_ready, 1);
    send_pkt(6, 5, 0, 0, 2, 10);
    chk("wr_rel_free", free_cnt, 69);
    take_desc(0);
    repeat (18) release_amt(64);
    chk("sat_free", free_cnt, 1024);
    release_amt(5);
    chk("sat_free2", free_cnt, 1024);

    // Async reset in the middle of a packet.
    wait_ready();
    in_sop = 1; in_des_port = 4'd8;
    cyc();
    in_sop = 0; in_vld = 1; in_data = 64'h1234;
    cyc();
    in_data = 64'h5678;
    cyc();
    rst = 0;
    #1;
    chk("mrst_wr_en", sram_wr_en, 0);
    chk("mrst_free", free_cnt, 1024);
    chk("mrst_desc_vld", desc_vld, 0);
    chk("mrst_ready", in_ready, 1);
    in_vld = 0;
    cyc();
    rst = 1;
    out_q.delete();
    cyc();
    send_pkt(12, 2, 0, 0, -1, 0);
    chk("post_rst_addr", desc_addr, 0);
    take_desc(0);

    // Random traffic.
    for (int p = 0; p < 30; p++) begin
      int n, rel_at, rel_amt;
      while (m_free < 64 && out_q.size() > 0) release_amt(out_q.pop_front());
      repeat ($urandom_range(0, 2)) begin
        in_vld = 1'($urandom); in_eop = 1'($urandom);
        cyc();
      end
      in_vld = 0; in_eop = 0;
      n = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 70));
      rel_at = -1; rel_amt = 0;
      if (n > 0 && out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rel_at = int'($urandom_range(0, n - 1));
        rel_amt = out_q.pop_front();
      end
      send_pkt(int'($urandom_range(0, 15)), n, 2, ($urandom_range(0, 7) == 0), rel_at, rel_amt);
      take_desc(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0 && out_q.size() > 0) release_amt(out_q.pop_front());
    end
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

endmodule

// File: doc/sram_write_ctrl.md
Name: sram_write_ctrl

Overview:
Sits directly downstream of write_arbiter. Consumes the arbitrated packet stream (sop / vld / eop / data plus destination port). Writes packet words into a circular SRAM data buffer and, for each finished packet, emits one descriptor (start address, length, destination port) to the queue manager. Tracks free buffer space, back-pressures the arbiter when space is short, and reclaims space when downstream releases finished packets.

Parameters:
data_width, 64, width of packet data words
addr_width, 10, SRAM address width; buffer depth = 2^addr_width words
port_width, 4, width of destination port number
max_pkt_len, 64, maximum words per packet (must be <= 2^addr_width)
len_width, 7, width of length fields; holds 0..max_pkt_len

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-low reset
in_sop  in  1  packet start; header-only cycle, no data
in_vld  in  1  in_data valid
in_eop  in  1  last word; accompanies final in_vld
in_data  in  data_width  packet word
in_des_port  in  port_width  destination port; sampled on accepted in_sop
in_ready  out  1  controller can accept sop or data this cycle
sram_wr_en  out  1  SRAM write strobe
sram_wr_addr  out  addr_width  SRAM write address
sram_wr_data  out  data_width  SRAM write data
desc_vld  out  1  descriptor valid
desc_ready  in  1  descriptor accepted
desc_addr  out  addr_width  packet start address
desc_len  out  len_width  words written
desc_port  out  port_width  destination port
desc_err  out  1  packet truncated or malformed
rel_vld  in  1  release strobe
rel_len  in  len_width  words returned to the free pool
free_cnt  out  addr_width+1  free words in the buffer

Behaviour:
- Reset (rst=0, async): state IDLE; wr_ptr=0; free_cnt=2^addr_width; all other outputs 0. Reset mid-packet discards the partial packet. No descriptor is produced for it.
- States: IDLE, WRITE, DESC.
- IDLE:
  - in_ready = (free_cnt >= max_pkt_len).
  - in_sop & in_ready: latch in_des_port; start_addr=wr_ptr; len=0; err=0; go to WRITE.
  - in_sop while in_ready=0 is ignored. Upstream holds it.
  - in_vld and in_eop in IDLE are ignored.
- WRITE:
  - in_ready=1.
  - Each in_vld with len < max_pkt_len: on the next cycle, sram_wr_en=1, sram_wr_addr=wr_ptr, sram_wr_data=in_data. Then wr_ptr+1 (wraps modulo 2^addr_width), len+1, free_cnt-1. Write latency is exactly one cycle.
  - in_vld with len == max_pkt_len: word discarded; err=1.
  - in_eop (with or without in_vld): go to DESC. A bare in_eop with len=0 gives desc_len=0 and desc_err=1.
  - in_sop in WRITE is ignored and sets err=1.
- DESC:
  - in_ready=0.
  - desc_vld=1 starting the cycle after eop is accepted, coincident with the last sram_wr_en.
  - desc_addr/len/port/err are held stable while desc_vld=1 & desc_ready=0.
  - desc_vld & desc_ready: go to IDLE next cycle; desc_vld drops.
- Free count:
  - free_cnt_next = free_cnt - wr + (rel_vld ? rel_len : 0).
  - Simultaneous write and release are both applied.
  - Result saturates at 2^addr_width; excess release is ignored.
- Sizing guarantee: sop is admitted only with >= max_pkt_len free words, so a write never overruns unreleased data.
- sram_wr_en is a single-cycle pulse per word. sram_wr_addr and sram_wr_data are don't-care when sram_wr_en=0, but are registered.

Test Plan:
- Reset then idle: free_cnt=1024, in_ready=1, desc_vld=0, sram_wr_en=0. Assert rst=0 mid-packet -> all outputs return to reset values immediately.
- Port 5, 4-word packet D0..D3: sram_wr_en pulses at addr 0..3 one cycle after each in_vld. Descriptor {addr=0, len=4, port=5, err=0} is valid with the last write. free_cnt ends at 1020.
- Hold desc_ready=0 for 10 cycles -> desc fields stable, in_ready=0, second in_sop not accepted. Raise desc_ready -> IDLE next cycle, second packet proceeds.
- 70-word packet -> 64 writes. Descriptor len=64, err=1. Words 65..70 produce no sram_wr_en.
- Wrap: preload wr_ptr=1022 via prior packets plus releases; 4-word packet -> addresses 1022, 1023, 0, 1; desc_addr=1022.
- Backpressure and release: fill until free_cnt=63 -> in_ready=0 in IDLE. rel_vld with rel_len=10 in the same cycle as a write -> free_cnt +9. Release beyond depth saturates at 1024.
